// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: start/done handshake and data bus for the BCD-to-binary converter.
interface bcd2bin_seq_if #(parameter int DIGITS = 2);
   localparam int W = 4 * DIGITS;
   logic         start;
   logic [W-1:0] bcd_in;
   logic         busy;
   logic         done;
   logic [W-1:0] bin_out;
   logic         error;
   modport master (output start, bcd_in, input busy, done, bin_out, error);
   modport slave  (input start, bcd_in, output busy, done, bin_out, error);
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: iterative BCD-to-binary converter using reverse double-dabble,
// one right shift plus per-digit subtract-3 correction per clock.
module bcd2bin_seq #(
   parameter int DIGITS = 2
) (
   input logic          clk,
   input logic          rst_n,
   bcd2bin_seq_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(W);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       state;
   logic [2*W-1:0]   sr;
   logic [2*W-1:0]   sh;
   logic [2*W-1:0]   nxt;
   logic [CW-1:0]    cnt;
   logic [W-1:0]     bin_q;
   logic             err_q;
   logic [DIGITS-1:0] bad;
   assign sh           = {1'b0, sr[2*W-1:1]};
   assign nxt[W-1:0]   = sh[W-1:0];
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign bad[i] = bus.bcd_in[4*i +: 4] > 4'd9;
      // a digit >= 8 after the shift received a borrowed 10 from the digit above
      assign nxt[W+4*i +: 4] = sh[W+4*i +: 4] >= 4'd8 ? sh[W+4*i +: 4] - 4'd3 : sh[W+4*i +: 4];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         bin_q <= '0;
         err_q <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.start) begin
            sr <= {bus.bcd_in, {W{1'b0}}};
            if (|bad) begin
               state <= DONE;
               bin_q <= '0;
               err_q <= 1'b1;
            end else begin
               state <= CONV;
               cnt   <= CW'(W - 1);
            end
         end
      end else if (state == CONV) begin
         sr  <= nxt;
         cnt <= cnt - CW'(1);
         if (cnt == '0) begin
            state <= DONE;
            bin_q <= nxt[W-1:0];
            err_q <= 1'b0;
         end
      end else begin
         state <= IDLE;
      end
   end
   assign bus.busy    = state != IDLE;
   assign bus.done    = state == DONE;
   assign bus.bin_out = bin_q;
   assign bus.error   = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed self-checking bench for bcd2bin_seq (DIGITS=2).
module tb_bcd2bin_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   lat;
   int   ndone;
   int   t_last;
   logic [7:0] res;
   logic       err;
   logic [7:0] rt;
   bcd2bin_seq_if #(.DIGITS(2)) bus ();
   bcd2bin_seq #(.DIGITS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // issue one start; lat counts edges up to the one after which done is seen (start edge = 1)
   task automatic run(input logic [7:0] v);
      bus.bcd_in = v;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 20) begin
         chk("busy_during", {31'd0, bus.busy}, 32'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.bin_out;
      err = bus.error;
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      chk("busy_after", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.bcd_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_bin", {24'd0, bus.bin_out}, 32'd0);
      chk("rst_err", {31'd0, bus.error}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(8'h42);
      chk("h42_lat", lat, 9);
      chk("h42_bin", {24'd0, res}, 32'd42);
      chk("h42_err", {31'd0, err}, 32'd0);
      for (int t = 0; t < 10; t++)
         for (int u = 0; u < 10; u++) begin
            run({4'(t), 4'(u)});
            chk("sweep_bin", {24'd0, res}, 32'(10 * t + u));
            chk("sweep_lat", lat, 9);
            rt = {4'(res / 10), 4'(res % 10)};
            chk("sweep_roundtrip", {24'd0, rt}, {24'd0, 4'(t), 4'(u)});
         end
      run(8'h3A);
      chk("h3A_lat", lat, 1);
      chk("h3A_err", {31'd0, err}, 32'd1);
      chk("h3A_bin", {24'd0, res}, 32'd0);
      run(8'hF0);
      chk("hF0_lat", lat, 1);
      chk("hF0_err", {31'd0, err}, 32'd1);
      chk("hF0_bin", {24'd0, res}, 32'd0);
      run(8'h07);
      chk("h07_err", {31'd0, err}, 32'd0);
      chk("h07_bin", {24'd0, res}, 32'd7);
      // restart attempt while busy, with new data on the bus
      bus.bcd_in = 8'h25;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      res = 8'hFF;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin
            bus.start  = 1'b1;
            bus.bcd_in = 8'h88;
         end
         if (i == 4) bus.start = 1'b0;
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            res = bus.bin_out;
         end
      end
      chk("ign_ndone", ndone, 1);
      chk("ign_bin", {24'd0, res}, 32'd25);
      // reset mid-conversion
      bus.bcd_in = 8'h63;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mrst_done", {31'd0, bus.done}, 32'd0);
      chk("mrst_bin", {24'd0, bus.bin_out}, 32'd0);
      chk("mrst_err", {31'd0, bus.error}, 32'd0);
      ndone = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("mrst_nodone", ndone, 0);
      run(8'h63);
      chk("h63_bin", {24'd0, res}, 32'd63);
      chk("h63_lat", lat, 9);
      // start held high: accepting edge is index 0
      bus.bcd_in = 8'h11;
      bus.start  = 1'b1;
      ndone  = 0;
      t_last = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            chk("held_gap", i - t_last, (ndone == 0) ? 9 : 10);
            chk("held_bin", {24'd0, bus.bin_out}, 32'd11);
            ndone++;
            t_last = i;
         end
      end
      bus.start = 1'b0;
      chk("held_ndone", ndone, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Iterative BCD-to-binary converter; the inverse of the existing binary-to-BCD display path.
- Takes a packed multi-digit BCD value, for example from keypad or switch entry. Returns the unsigned binary equivalent after a fixed number of clock cycles.
- Uses reverse double-dabble: one right shift per cycle, with a subtract-3 correction on each BCD digit.
- Start/done handshake, so it can sit between an input-capture block and the ALU/datapath.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in (>=1); localparam W = 4*DIGITS is the data width.

Ports:
- clk      in   1    system clock, all logic on rising edge
- rst_n    in   1    synchronous active-low reset
- start    in   1    request conversion; sampled only in IDLE
- bcd_in   in   W    packed BCD, digit i at bits [4i+3:4i], digit 0 = units
- busy     out  1    high in CONV and DONE
- done     out  1    one-cycle pulse when result/error valid
- bin_out  out  W    binary result, upper bits zero; held until next done
- error    out  1    set with done when any input digit >9; held until next done

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, bin_out=0, error=0.
  - Shift register and counter cleared.
  - Applies mid-conversion too: the conversion is abandoned and no done is produced.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at an edge:
  - Latch bcd_in into the upper half of a 2W-bit register {bcd_sr, bin_sr}; clear bin_sr.
  - Any digit >9: go to DONE with pending error=1.
  - All digits valid: go to CONV with cnt=W-1.
  - start=0: stay in IDLE.
- CONV, each cycle:
  - Logically shift {bcd_sr, bin_sr} right by 1, with 0 into the MSB.
  - Then, for every digit of the shifted bcd_sr, if the digit >=8, subtract 3. Corrections are applied in parallel within the same cycle.
  - cnt decrements. When cnt==0 at the edge, the final step is taken and the state moves to DONE.
- DONE, one cycle:
  - done=1.
  - On the edge entering DONE, bin_out is loaded with the result (bin_sr after the final step), or with 0 if error. error is loaded at the same edge.
  - DONE returns to IDLE unconditionally.
- Latency:
  - Valid input: done is high in the cycle W+1 edges after the start edge (DIGITS=2: 9 edges).
  - Invalid input: done is high 1 edge after the start edge.
- start while busy=1 (CONV or DONE) is ignored; it is not queued.
- start held high continuously: back-to-back conversions, with one IDLE cycle between done and the next accept.
- bcd_in is only sampled at the accepting edge; later changes do not affect the result in flight.
- Result range: 0 .. 10^DIGITS-1, which fits in W bits for all DIGITS>=1.
- No wrap-around or overflow is possible.

Test Plan:
- Reset, then bcd_in=8'h42, start pulse → busy high for 9 cycles; done pulse 9 edges after start; bin_out=8'd42 (0x2A), error=0.
- Sweep bcd_in over 8'h00..8'h99 (valid codes only), one start per conversion → bin_out equals the decimal value each time (8'h99→8'd99, 8'h00→0, 8'h10→10), and matches the binary-to-BCD encoder run in the opposite direction.
- bcd_in=8'h3A or 8'hF0, start → done one edge after start, error=1, bin_out=0. A following valid 8'h07 conversion → error=0, bin_out=7.
- start pulsed again 3 cycles into a 8'h25 conversion, with bcd_in changed to 8'h88 → ignored; result 25; exactly one done pulse.
- rst_n=0 for one edge mid-conversion of 8'h63 → next cycle busy=0, done never pulses, bin_out=0, error=0; a new start then converts normally.
- start held at 1 with bcd_in=8'h11 → done pulses every 10 cycles, bin_out=11 each time.
